calc_sequencer: RTL and testbench

Initiator side of the 4-bit calculator port. It accepts operation requests (a, b, mode) over a valid/ready handshake and buffers them in a small FIFO. It drives them one at a time onto the calculator's a/b/MODO inputs, waits out the calculator's one-cycle registered latency, captures {rco, c}, and returns each result over a valid/ready response channel in request order.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_req_fifo.sv | 51 +++++
 rtl/calc_sequencer.sv | 111 +++++++++++
 tb/tb_calc_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: operation modes, FSM
// state encoding and the request record layout {mode, b, a}.
package calc_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_SHL = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_DRIVE = S_DRIVE,
        ST_WAIT  = S_WAIT,
        ST_CAPT  = S_CAPT,
        ST_RESP  = S_RESP
    } state_e;

    // Request record is {mode, b, a}: 2 mode bits plus two operands.
    function automatic int req_w(input int width);
        return 2 + 2 * width;
    endfunction

endpackage

// File: rtl/calc_req_fifo.sv
// Synchronous request FIFO; a push while full and a pop while empty are
// ignored. Read data is the current head (show-ahead).
module calc_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    // Fullness is judged before any same-cycle pop, so a full FIFO refuses.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Feeds buffered requests one at a time to the registered calculator and
// returns each captured {rco, c} in request order over a valid/ready channel.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_mode,
    output logic [WIDTH-1:0] calc_a,
    output logic [WIDTH-1:0] calc_b,
    output logic [1:0]       calc_modo,
    input  logic [WIDTH-1:0] calc_c,
    input  logic             calc_rco,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_rco,
    output logic [1:0]       rsp_mode,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int RW = req_w(WIDTH);

    state_e                  state_q;
    logic [WIDTH-1:0]        calc_a_q, calc_b_q, rsp_c_q;
    logic [1:0]              calc_modo_q, rsp_mode_q;
    logic                    rsp_valid_q, rsp_rco_q;
    logic [CNT_W-1:0]        op_count_q;

    logic [RW-1:0]           fifo_wdata, fifo_rdata;
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(DEPTH):0]  fifo_cnt;
    logic                    unused_cnt;

    assign fifo_wdata = {req_mode, req_b, req_a};
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    assign unused_cnt = ^fifo_cnt;

    calc_req_fifo #(.DEPTH(DEPTH), .DW(RW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_valid),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign req_ready = !fifo_full;
    assign calc_a    = calc_a_q;
    assign calc_b    = calc_b_q;
    assign calc_modo = calc_modo_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_rco   = rsp_rco_q;
    assign rsp_mode  = rsp_mode_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            calc_a_q    <= '0;
            calc_b_q    <= '0;
            calc_modo_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_rco_q   <= 1'b0;
            rsp_mode_q  <= '0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (!fifo_empty) begin
                    calc_a_q    <= fifo_rdata[WIDTH-1:0];
                    calc_b_q    <= fifo_rdata[2*WIDTH-1:WIDTH];
                    calc_modo_q <= fifo_rdata[RW-1 -: 2];
                    state_q     <= ST_DRIVE;
                end
                // Calculator samples its inputs at the end of DRIVE; the
                // result is on calc_c/calc_rco during WAIT and CAPT.
                ST_DRIVE: state_q <= ST_WAIT;
                ST_WAIT:  state_q <= ST_CAPT;
                ST_CAPT: begin
                    rsp_c_q     <= calc_c;
                    rsp_rco_q   <= calc_rco;
                    rsp_mode_q  <= calc_modo_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    op_count_q  <= op_count_q + 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized scoreboard bench for calc_sequencer with a registered calculator
// model and a transaction-level timing model of the request/response flow.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk, rst;
    logic             req_valid, req_ready;
    logic [WIDTH-1:0] req_a, req_b;
    logic [1:0]       req_mode;
    logic [WIDTH-1:0] calc_a, calc_b, calc_c;
    logic [1:0]       calc_modo;
    logic             calc_rco;
    logic             rsp_valid, rsp_ready, rsp_rco;
    logic [WIDTH-1:0] rsp_c;
    logic [1:0]       rsp_mode;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    calc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .calc_a(calc_a), .calc_b(calc_b), .calc_modo(calc_modo),
        .calc_c(calc_c), .calc_rco(calc_rco),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_rco(rsp_rco), .rsp_mode(rsp_mode),
        .busy(busy), .op_count(op_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // 5-bit {rco,c} from plain integer arithmetic
    function automatic logic [WIDTH:0] ref_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [1:0] m);
        int r;
        case (m)
            MODE_ADD: r = int'(a) + int'(b);
            MODE_SUB: r = int'(a) - int'(b);
            MODE_MUL: r = int'(a) * int'(b);
            MODE_SHL: r = int'(a) * 2;
            default:  r = 0;
        endcase
        return (WIDTH+1)'(r & ((1 << (WIDTH+1)) - 1));
    endfunction

    // Calculator: one-cycle registered, shares rst
    always @(posedge clk) begin
        if (rst) {calc_rco, calc_c} <= '0;
        else     {calc_rco, calc_c} <= ref_res(calc_a, calc_b, calc_modo);
    end

    // Transaction model: occupancy, in-flight op with countdown to response
    int               m_occ = 0;
    bit               m_busy = 0;
    int               m_cd = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               m_push, m_pop;
    bit               started = 0;
    logic [WIDTH+2:0] sb[$];
    int               hs_cyc[$];

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            m_occ = 0; m_busy = 0; m_cd = 0; m_cnt = '0;
            sb.delete();
        end else begin
            m_push = req_valid && (m_occ < DEPTH);
            m_pop  = !m_busy && (m_occ > 0);
            if (m_busy) begin
                if (m_cd > 0) m_cd--;
                else if (rsp_ready) begin m_busy = 0; m_cnt++; end
            end else if (m_pop) begin
                m_busy = 1;
                m_cd   = 3;
            end
            m_occ = m_occ + int'(m_push) - int'(m_pop);
            if (m_push) sb.push_back({req_mode, ref_res(req_a, req_b, req_mode)});
        end
    end

    // Monitor: control signals every cycle, payload against scoreboard head
    always @(negedge clk) begin
        if (started) begin
            chk("rsp_valid", rsp_valid, int'(m_busy && m_cd == 0));
            chk("busy", busy, int'(m_busy));
            chk("req_ready", req_ready, int'(m_occ < DEPTH));
            chk("op_count", op_count, m_cnt);
            if (rsp_valid && m_busy && m_cd == 0) begin
                if (sb.size() == 0) timeout("scoreboard empty on response");
                else begin
                    chk("rsp_c", rsp_c, sb[0][WIDTH-1:0]);
                    chk("rsp_rco", rsp_rco, sb[0][WIDTH]);
                    chk("rsp_mode", rsp_mode, sb[0][WIDTH+2:WIDTH+1]);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        hs_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    bit rnd_rdy = 0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] m);
        bit ok = 0;
        req_valid = 1'b1; req_a = a; req_b = b; req_mode = m;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = req_ready;
            step();
        end
        req_valid = 1'b0;
        if (!ok) timeout("push accept");
    endtask

    task automatic push_rand();
        push(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom));
    endtask

    task automatic drain();
        bit done = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (sb.size() == 0 && !m_busy) done = 1;
            else step();
        end
        if (!done) timeout("drain");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_mode = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step();
        chk("reset calc_a", calc_a, 0);
        chk("reset calc_b", calc_b, 0);
        chk("reset calc_modo", calc_modo, 0);
        chk("reset rsp_c", rsp_c, 0);
        chk("reset rsp_rco", rsp_rco, 0);
        chk("reset rsp_mode", rsp_mode, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset req_ready", req_ready, 1);

        // Single ADD 9+8 -> rco=1, c=0001
        rsp_ready = 1'b1;
        push(4'd9, 4'd8, MODE_ADD);
        drain();
        chk("add rsp_c", rsp_c, 1);
        chk("add rsp_rco", rsp_rco, 1);
        chk("add op_count", op_count, 1);

        // Back-to-back burst, 5-cycle spacing
        hs_cyc.delete();
        push(4'd3, 4'd5, MODE_SUB);
        push(4'd7, 4'd3, MODE_MUL);
        push(4'b1011, 4'd0, MODE_SHL);
        push(4'd2, 4'd2, MODE_ADD);
        drain();
        chk("burst responses", hs_cyc.size(), 4);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("burst spacing", hs_cyc[i] - hs_cyc[i-1], 5);
        chk("burst last rsp_c", rsp_c, 4);
        chk("burst last rsp_rco", rsp_rco, 0);

        // Backpressure with FIFO filling up behind a held response
        rsp_ready = 1'b0;
        push(4'd5, 4'd6, MODE_ADD);
        for (int i = 0; i < 50 && !rsp_valid; i++) step();
        if (!rsp_valid) timeout("bp rsp_valid");
        for (int i = 0; i < DEPTH; i++) push_rand();
        repeat (10) step();
        chk("bp full req_ready", req_ready, 0);
        chk("bp held rsp_c", rsp_c, 11);

        // Full boundary: pop and push in the same edge while full
        rsp_ready = 1'b1; req_valid = 1'b1; req_a = 4'd15; req_b = 4'd15; req_mode = MODE_MUL;
        step();
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("boundary req_ready", req_ready, 1);
        chk("boundary busy", busy, 1);
        drain();

        // Reset during WAIT with two entries queued
        rsp_ready = 1'b1;
        push_rand(); push_rand(); push_rand();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst rsp_valid", rsp_valid, 0);
        chk("midrst req_ready", req_ready, 1);
        chk("midrst op_count", op_count, 0);
        repeat (20) step();

        // Random traffic with random backpressure; long enough to wrap op_count
        rnd_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            push_rand();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step();
        end
        rnd_rdy = 0;
        drain();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
